// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU memory port arbiter: ownership, FSM state
// and the latched memory request.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_s;

    function automatic logic [ARB_BE_W-1:0] be_all_ones();
        return '1;
    endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Data-priority grant decision with a saturating fetch starvation counter.
module arb_prio_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req_valid,
    input  logic ls_req_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("arb_prio_starve: STARVE_LIMIT must be at least 1");
    end

    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_forced;

    always_comb begin
        fetch_forced = if_req_valid && (starve_cnt == LIMIT_C);
        grant_ls     = arb_en && ls_req_valid && !fetch_forced;
        grant_if     = arb_en && if_req_valid && !grant_ls;
    end

    // Only counts LSU wins that actually held a fetch back.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_ls) begin
            if (!if_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT_C) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and the
// LSU, routing each response back to the requester that issued it.
//
//  state | meaning
//  IDLE  | no access in flight; grant decided combinationally this cycle
//  ISSUE | latched request presented on mem_*, waiting for mem_req_ready
//  WAIT  | request accepted, waiting for mem_rsp_valid
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic                    ls_we,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic                    busy
);

    // The request struct lives in the package, so its widths pin ours.
    if (ADDR_WIDTH != ARB_ADDR_W || DATA_WIDTH != ARB_DATA_W || (DATA_WIDTH % 8) != 0) begin : g_width_check
        $error("mem_port_arbiter: ADDR_WIDTH/DATA_WIDTH must match mem_arb_pkg");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    owner_e     owner_q;
    mem_req_s   req_q;
    logic       arb_en;
    logic       grant_if;
    logic       grant_ls;

    assign arb_en = (state_q == IDLE);

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .if_req_valid (if_req_valid),
        .ls_req_valid (ls_req_valid),
        .grant_if     (grant_if),
        .grant_ls     (grant_ls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_if || grant_ls) state_d = ISSUE;
            ISSUE:   if (mem_req_ready)        state_d = WAIT;
            WAIT:    if (mem_rsp_valid)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = grant_if;
        ls_req_ready  = grant_ls;
        mem_req_valid = (state_q == ISSUE);
        busy          = (state_q != IDLE);
        mem_we        = req_q.we;
        mem_be        = req_q.be;
        mem_addr      = req_q.addr;
        mem_wdata     = req_q.wdata;
    end

    // Fetches are always full-word reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWNER_IF;
            req_q   <= '0;
        end else if (grant_ls) begin
            owner_q     <= OWNER_LS;
            req_q.we    <= ls_we;
            req_q.be    <= ls_be;
            req_q.addr  <= ls_addr;
            req_q.wdata <= ls_wdata;
        end else if (grant_if) begin
            owner_q     <= OWNER_IF;
            req_q.we    <= 1'b0;
            req_q.be    <= be_all_ones();
            req_q.addr  <= if_addr;
            req_q.wdata <= '0;
        end
    end

    // Responses are only accepted in WAIT; strays elsewhere fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            if (state_q == WAIT && mem_rsp_valid) begin
                if (owner_q == OWNER_LS) begin
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_data  <= mem_rsp_data;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= mem_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level
// model of arbitration, starvation and the memory side.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;
    localparam int NCYC  = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          ls_req_valid, ls_req_ready, ls_we;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_rsp_valid;
    logic [DW-1:0] ls_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_we         (ls_we),
        .ls_be         (ls_be),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    typedef struct {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          ls;
        logic [DW-1:0] data;
    } rsp_t;

    req_t mem_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pending requester transactions, held until granted.
    logic          if_want, ls_want;
    logic [AW-1:0] if_a, ls_a;
    logic          ls_w;
    logic [BW-1:0] ls_b;
    logic [DW-1:0] ls_d;

    task automatic new_if();
        if_want = 1'b1;
        if_a    = {$urandom_range(0, 4095), 2'b00};
    endtask

    task automatic new_ls();
        ls_want = 1'b1;
        ls_w    = 1'($urandom_range(0, 1));
        ls_b    = BW'($urandom_range(0, (1 << BW) - 1));
        ls_a    = {$urandom_range(0, 4095), 2'b00};
        ls_d    = $urandom;
    endtask

    initial begin
        int   ph, ph_next, starve, rsp_wait;
        bit   rsp_pend, rsp_now, nrst, force_stray, cur_ls, exp_if, exp_ls, rst_req;
        logic [DW-1:0] rsp_dat;
        ph = 0; ph_next = 0; starve = 0; rsp_wait = 0;
        rsp_pend = 0; rsp_now = 0; nrst = 0; force_stray = 0; cur_ls = 0; rst_req = 0;
        rsp_dat = '0;
        if_want = 0; ls_want = 0; if_a = '0; ls_a = '0; ls_w = 0; ls_b = '0; ls_d = '0;

        rst = 1'b1;
        if_req_valid = 0; if_addr = '0; ls_req_valid = 0; ls_we = 0; ls_be = '0;
        ls_addr = '0; ls_wdata = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_mem_req_valid", mem_req_valid, 0);
        check("reset_if_rsp_valid", if_rsp_valid, 0);
        check("reset_ls_rsp_valid", ls_rsp_valid, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_be", mem_be, 0);
        check("reset_rsp_data", {if_rsp_data, ls_rsp_data}, 0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            ph = ph_next;
            rst = nrst;
            if_req_valid = if_want;
            if_addr      = if_a;
            ls_req_valid = ls_want;
            ls_we        = ls_w;
            ls_be        = ls_b;
            ls_addr      = ls_a;
            ls_wdata     = ls_d;
            if (cyc >= 1000 && cyc < 1400) mem_req_ready = ($urandom_range(0, 5) == 0);
            else                           mem_req_ready = ($urandom_range(0, 3) != 0);
            rsp_now       = 0;
            mem_rsp_valid = 0;
            mem_rsp_data  = $urandom;
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1;
                    mem_rsp_data  = rsp_dat;
                    rsp_now       = 1;
                    rsp_pend      = 0;
                end else begin
                    rsp_wait--;
                end
            end else if (force_stray || $urandom_range(0, 9) == 0) begin
                mem_rsp_valid = 1;
            end
            force_stray = 0;
            if (cyc == 700 || cyc == 2200) rst_req = 1;

            @(negedge clk);
            check("busy", busy, (ph != 0));
            check("mem_req_valid", mem_req_valid, (ph == 1));
            exp_ls = 0;
            exp_if = 0;
            if (ph == 0) begin
                exp_ls = ls_want && !(if_want && starve == LIMIT);
                exp_if = if_want && !exp_ls;
            end
            check("if_req_ready", if_req_ready, exp_if);
            check("ls_req_ready", ls_req_ready, exp_ls);

            ph_next = ph;
            if (rst) begin
                ph_next     = 0;
                starve      = 0;
                nrst        = 0;
                force_stray = 1;
            end else begin
                if (exp_ls) begin
                    mem_q.push_back('{ls_w, ls_b, ls_a, ls_d});
                    starve  = if_want ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                    cur_ls  = 1;
                    ls_want = 0;
                    ph_next = 1;
                end else if (exp_if) begin
                    mem_q.push_back('{1'b0, {BW{1'b1}}, if_a, {DW{1'b0}}});
                    starve  = 0;
                    cur_ls  = 0;
                    if_want = 0;
                    ph_next = 1;
                end
                if (ph == 1 && mem_req_ready) begin
                    ph_next  = 2;
                    rsp_pend = 1;
                    rsp_wait = $urandom_range(0, 3);
                    rsp_dat  = $urandom;
                    rsp_q.push_back('{cur_ls, rsp_dat});
                end
                if (rsp_now) ph_next = 0;
                // Reset while the access is outstanding: the response is dropped.
                if (rst_req && ph == 2 && rsp_pend) begin
                    nrst     = 1;
                    rsp_pend = 0;
                    rsp_q.delete();
                    rst_req  = 0;
                end
            end
            if (cyc < NCYC - 100) begin
                if (!if_want && $urandom_range(0, 3) != 0) new_if();
                if (!ls_want && $urandom_range(0, 4) != 0) new_ls();
            end
        end

        repeat (3) @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        check("final_busy", busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Response monitor: every pulse must match the oldest outstanding access.
    logic [DW-1:0] last_if = '0;
    logic [DW-1:0] last_ls = '0;
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            last_if = '0;
            last_ls = '0;
        end else begin
            check("dual_rsp_pulse", if_rsp_valid & ls_rsp_valid, 0);
            if (if_rsp_valid || ls_rsp_valid) begin
                check("rsp_expected", (rsp_q.size() != 0), 1);
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    check("rsp_owner", ls_rsp_valid, e.ls);
                    check("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
                end
            end
            if (if_rsp_valid) last_if = if_rsp_data;
            else check("if_rsp_data_hold", if_rsp_data, last_if);
            if (ls_rsp_valid) last_ls = ls_rsp_data;
            else check("ls_rsp_data_hold", ls_rsp_data, last_ls);
        end
    end

    // Memory-side monitor: request content at acceptance, stability under stall.
    bit            prev_stall = 0;
    logic          prev_we;
    logic [BW-1:0] prev_be;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (mem_req_valid && prev_stall) begin
                check("mem_hold_ctrl", {mem_we, mem_be}, {prev_we, prev_be});
                check("mem_hold_addr", mem_addr, prev_addr);
                check("mem_hold_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req_valid && mem_req_ready) begin
                check("mem_req_expected", (mem_q.size() != 0), 1);
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_be", mem_be, e.be);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_we    = mem_we;
            prev_be    = mem_be;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

endmodule
